// File: rtl/vga_sync_ctrl.sv
// -----------------------------------------------------------------------------
// vga_sync_ctrl
//
// Single-clock VGA timing controller. A free-running divider produces a
// one-CLKIN-wide pixel enable (pe) so all logic stays on CLKIN; no divided
// clock is exported. Stage 0 holds the horizontal/vertical counters and
// decodes the pixel request for the upstream source. Stage 1 registers sync,
// video-on and pixel data together so that everything reaching the connector
// is mutually aligned, one pixel period behind the counters.
//
// Ports:
//   CLKIN        system clock (100 MHz nominal)
//   ACLR         asynchronous reset, active-high
//   EN           run enable; low restarts and holds everything at reset values
//   RGB_IN       12-bit pixel for the coordinate currently on HCOUNT/VCOUNT
//   HCOUNT       stage-0 horizontal pixel index
//   VCOUNT       stage-0 line index
//   PIX_REQ      stage-0 coordinate is visible (combinational decode)
//   FRAME_START  one-CLKIN pulse after the counters wrap to (0,0)
//   HSYNC        stage-1 horizontal sync, active-low
//   VSYNC        stage-1 vertical sync, active-low
//   VIDEO_ON     stage-1 visible flag
//   RGB_OUT      stage-1 pixel, forced to zero outside the visible area
// -----------------------------------------------------------------------------
module vga_sync_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CW        = 10
) (
  input  logic          CLKIN,
  input  logic          ACLR,
  input  logic          EN,
  input  logic [11:0]   RGB_IN,
  output logic [CW-1:0] HCOUNT,
  output logic [CW-1:0] VCOUNT,
  output logic          PIX_REQ,
  output logic          FRAME_START,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          VIDEO_ON,
  output logic [11:0]   RGB_OUT
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);

  // Divider and stage-0 counters
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  // Stage-1 output registers
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          frame_start_q, frame_start_d;

  // Stage-0 decode
  logic pe;
  logic h_last, v_last;
  logic visible;
  logic in_hsync, in_vsync;

  always_comb begin
    pe       = (div_q == DIV_LAST);
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    visible  = (h_q < H_VIS) && (v_q < V_VIS);
    in_hsync = (h_q >= HS_START) && (h_q < HS_END);
    in_vsync = (v_q >= VS_START) && (v_q < VS_END);
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the branches below can leave a signal unassigned and infer
    // a latch.
    div_d         = div_q;
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;

    if (!EN) begin
      // Synchronous restart: takes priority over a pe that would fire now.
      div_d      = '0;
      h_d        = '0;
      v_d        = '0;
      hsync_d    = 1'b1;
      vsync_d    = 1'b1;
      video_on_d = 1'b0;
      rgb_d      = '0;
    end else begin
      div_d = pe ? '0 : div_q + 1'b1;
      if (pe) begin
        h_d = h_last ? '0 : h_q + 1'b1;
        if (h_last) begin
          v_d = v_last ? '0 : v_q + 1'b1;
        end
        // Stage 1 captures the decode of the coordinate being left, which
        // keeps sync, video-on and pixel data on the same pixel.
        hsync_d       = ~in_hsync;
        vsync_d       = ~in_vsync;
        video_on_d    = visible;
        rgb_d         = visible ? RGB_IN : 12'h000;
        frame_start_d = h_last & v_last;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLKIN or posedge ACLR) begin
    if (ACLR) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HCOUNT      = h_q;
  assign VCOUNT      = v_q;
  assign PIX_REQ     = EN & visible;
  assign FRAME_START = frame_start_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign VIDEO_ON    = video_on_q;
  assign RGB_OUT     = rgb_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_ctrl
//
// Bench for vga_sync_ctrl using a reduced raster (15x8 pixels, CLK_DIV=4) so
// whole frames fit in a short run. A reference model derives every output from
// the number of enabled CLKIN edges since the last restart: the pixel index is
// that count divided by CLK_DIV, and the raster position and sync windows
// follow by plain division/modulo. Directed checks with hand-computed numbers
// pin the model itself.
// -----------------------------------------------------------------------------
module tb_vga_sync_ctrl;

  localparam int CD  = 4;
  localparam int HV  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 2;
  localparam int VV  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int CW  = 10;
  localparam int HT  = HV + HFP + HSW + HBP;   // 15
  localparam int VT  = VV + VFP + VSW + VBP;   // 8
  localparam int F   = HT * VT;                // 120 pixels per frame

  logic          CLKIN = 1'b0;
  logic          ACLR  = 1'b0;
  logic          EN    = 1'b1;
  logic [11:0]   RGB_IN;
  logic [CW-1:0] HCOUNT, VCOUNT;
  logic          PIX_REQ, FRAME_START, HSYNC, VSYNC, VIDEO_ON;
  logic [11:0]   RGB_OUT;

  // Pixel source: constant colour, or HCOUNT[3:0] replicated.
  logic          src_mode  = 1'b0;
  logic [11:0]   const_rgb = 12'hFFF;
  assign RGB_IN = src_mode ? {3{HCOUNT[3:0]}} : const_rgb;

  vga_sync_ctrl #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .CW(CW)
  ) dut (
    .CLKIN(CLKIN), .ACLR(ACLR), .EN(EN), .RGB_IN(RGB_IN),
    .HCOUNT(HCOUNT), .VCOUNT(VCOUNT), .PIX_REQ(PIX_REQ),
    .FRAME_START(FRAME_START), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .VIDEO_ON(VIDEO_ON), .RGB_OUT(RGB_OUT)
  );

  always #5 CLKIN = ~CLKIN;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int          n = 0;          // enabled CLKIN edges since last restart
  logic [11:0] rgb_lat = '0;   // pixel the source offered at the last pe edge

  always @(posedge CLKIN or posedge ACLR) begin
    if (ACLR) begin
      n = 0;
      rgb_lat = '0;
    end else if (!EN) begin
      n = 0;
    end else begin
      int pos;
      pos = (n / CD) % F;
      n++;
      if (n % CD == 0)
        rgb_lat = src_mode ? {3{4'(pos % HT)}} : const_rgb;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge CLKIN) begin
    if (cmp_en) begin
      int p, pos, h, v, pp, ph, pv;
      bit vis;
      p   = n / CD;
      pos = p % F;
      h   = pos % HT;
      v   = pos / HT;
      check("hcount", 32'(HCOUNT), 32'(h));
      check("vcount", 32'(VCOUNT), 32'(v));
      check("pix_req", 32'(PIX_REQ), 32'(EN && h < HV && v < VV));
      check("frame_start", 32'(FRAME_START),
            32'(p >= 1 && n % CD == 0 && pos == 0));
      if (p == 0) begin
        check("hsync", 32'(HSYNC), 32'd1);
        check("vsync", 32'(VSYNC), 32'd1);
        check("video_on", 32'(VIDEO_ON), 32'd0);
        check("rgb_out", 32'(RGB_OUT), 32'd0);
      end else begin
        pp  = (p - 1) % F;
        ph  = pp % HT;
        pv  = pp / HT;
        vis = (ph < HV) && (pv < VV);
        check("hsync", 32'(HSYNC), 32'(!(ph >= HV + HFP && ph < HV + HFP + HSW)));
        check("vsync", 32'(VSYNC), 32'(!(pv >= VV + VFP && pv < VV + VFP + VSW)));
        check("video_on", 32'(VIDEO_ON), 32'(vis));
        check("rgb_out", 32'(RGB_OUT), vis ? 32'(rgb_lat) : 32'd0);
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic wait_for(input int h, input int v, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * F * CD && !found; i++) begin
      tick();
      if (HCOUNT == CW'(h) && VCOUNT == CW'(v)) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    int hs_low, vs_low, pr_high, vo_high, fs_high, rgb_nz, line_hs;
    int fs_idx[$];

    #1 ACLR = 1'b1;
    #1 cmp_en = 1'b1;
    tick();
    tick();
    // Reset state; PIX_REQ follows its decode with EN high.
    check("rst_hcount", 32'(HCOUNT), 32'd0);
    check("rst_hsync", 32'(HSYNC), 32'd1);
    check("rst_vsync", 32'(VSYNC), 32'd1);
    check("rst_pix_req", 32'(PIX_REQ), 32'd1);
    check("rst_rgb", 32'(RGB_OUT), 32'd0);

    // Release: first pe on the 4th edge; pixel (0,0) reaches stage 1 there.
    ACLR = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("first_pe_hold", 32'(HCOUNT), 32'd0);
    end
    tick();
    check("first_pe_hcount", 32'(HCOUNT), 32'd1);
    check("first_video_on", 32'(VIDEO_ON), 32'd1);
    check("first_rgb", 32'(RGB_OUT), 32'hFFF);

    // Two frames with RGB_IN=FFF. Ticks 5..964 after release; totals are
    // accumulated over the one-frame window 5..484 (any full period works).
    hs_low = 0; vs_low = 0; pr_high = 0; vo_high = 0; fs_high = 0;
    rgb_nz = 0; line_hs = 0;
    for (int i = 5; i <= 964; i++) begin
      tick();
      if (FRAME_START) fs_idx.push_back(i);
      if (i <= 484) begin
        hs_low  += int'(!HSYNC);
        vs_low  += int'(!VSYNC);
        pr_high += int'(PIX_REQ);
        vo_high += int'(VIDEO_ON);
        fs_high += int'(FRAME_START);
        rgb_nz  += int'(RGB_OUT != 12'h000);
        if (i <= 64) line_hs += int'(!HSYNC);
      end
    end
    check("hsync_low_per_line", 32'(line_hs), 32'd12);      // 3 px * 4
    check("hsync_low_per_frame", 32'(hs_low), 32'd96);      // 8 lines * 12
    check("vsync_low_per_frame", 32'(vs_low), 32'd120);     // 2 lines * 60
    check("pix_req_per_frame", 32'(pr_high), 32'd128);      // 4 * 8 * 4
    check("video_on_per_frame", 32'(vo_high), 32'd128);
    check("rgb_nonzero_per_frame", 32'(rgb_nz), 32'd128);
    check("frame_start_width", 32'(fs_high), 32'd1);
    check("frame_start_count", 32'(fs_idx.size()), 32'd2);
    if (fs_idx.size() == 2) begin
      check("frame_start_first", 32'(fs_idx[0]), 32'd480);
      check("frame_start_period", 32'(fs_idx[1] - fs_idx[0]), 32'd480);
    end

    // Pattern source: HCOUNT[3:0] replicated, seen with one pixel of lag.
    src_mode = 1'b1;
    wait_for(3, 1, "wait_pattern");
    for (int i = 0; i < CD; i++) tick();
    check("pattern_rgb", 32'(RGB_OUT), 32'h333);
    for (int i = 0; i < F * CD; i++) tick();

    // Mid-frame asynchronous reset while both syncs are low.
    wait_for(11, 6, "wait_mid_frame");
    check("pre_aclr_hsync", 32'(HSYNC), 32'd0);
    check("pre_aclr_vsync", 32'(VSYNC), 32'd0);
    #1 ACLR = 1'b1;
    #1;
    check("aclr_hsync", 32'(HSYNC), 32'd1);
    check("aclr_vsync", 32'(VSYNC), 32'd1);
    check("aclr_hcount", 32'(HCOUNT), 32'd0);
    check("aclr_vcount", 32'(VCOUNT), 32'd0);
    check("aclr_rgb", 32'(RGB_OUT), 32'd0);
    tick();
    tick();
    ACLR = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("aclr_restart_hold", 32'(HCOUNT), 32'd0);
    tick();
    check("aclr_restart_pe", 32'(HCOUNT), 32'd1);

    // Three more edges leave a pe pending; EN low must win over it.
    for (int i = 0; i < 3; i++) tick();
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("en_low_hcount", 32'(HCOUNT), 32'd0);
      check("en_low_video_on", 32'(VIDEO_ON), 32'd0);
      check("en_low_pix_req", 32'(PIX_REQ), 32'd0);
    end
    EN = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("en_restart_hold", 32'(HCOUNT), 32'd0);
    tick();
    check("en_restart_pe", 32'(HCOUNT), 32'd1);
    for (int i = 0; i < 2 * HT * CD; i++) tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Single-clock VGA timing controller for the 100 MHz design. It generates a pixel-rate enable internally instead of exporting a divided clock. It sequences horizontal and vertical counters, requests pixel data from the upstream pixel source, and drives registered, mutually aligned HSYNC/VSYNC/VIDEO_ON/RGB_OUT to the VGA connector. Default timing is 640x480 @ 60 Hz with a 25 MHz pixel rate.

## Interface
Parameters:
- CLK_DIV, 4: CLKIN cycles per pixel; must be ≥ 2.
- H_VISIBLE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal segments, in pixels.
- V_VISIBLE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical segments, in lines.
- CW, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1.
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is the analogous vertical sum (default 525).

Ports:
- CLKIN  in  1  system clock, 100 MHz.
- ACLR  in  1  asynchronous reset, active-high.
- EN  in  1  run enable; low = synchronous restart and hold.
- RGB_IN  in  12  pixel for the coordinate on HCOUNT/VCOUNT.
- HCOUNT  out  CW  current horizontal pixel index (stage 0).
- VCOUNT  out  CW  current line index (stage 0).
- PIX_REQ  out  1  high while stage-0 coordinate is visible.
- FRAME_START  out  1  one-CLKIN pulse when counters wrap to (0,0).
- HSYNC  out  1  horizontal sync, active-low (stage 1).
- VSYNC  out  1  vertical sync, active-low (stage 1).
- VIDEO_ON  out  1  stage-1 visible flag.
- RGB_OUT  out  12  registered pixel to DAC; zero when not visible.

## Operation
- Divider: `div` counts 0..CLK_DIV-1 and wraps. pe = (div == CLK_DIV-1), combinational. All counter and pipeline registers update only on CLKIN edges where pe = 1.
- Stage 0 (counters), on pe:
  - HCOUNT increments; at H_TOTAL-1 it wraps to 0.
  - VCOUNT increments only on an HCOUNT wrap; at V_TOTAL-1 it wraps to 0.
- PIX_REQ = EN & (HCOUNT < H_VISIBLE) & (VCOUNT < V_VISIBLE), decoded combinationally from registers.
- Pixel source contract: RGB_IN must be valid for the current HCOUNT/VCOUNT before the next pe edge, which gives a window of CLK_DIV CLKIN cycles.
- Stage 1, on pe, registered from the stage-0 decode:
  - VIDEO_ON <= visible(HCOUNT, VCOUNT).
  - HSYNC <= ~(H_VISIBLE+H_FP ≤ HCOUNT < H_VISIBLE+H_FP+H_SYNC). Default: low for HCOUNT 656..751.
  - VSYNC <= ~(V_VISIBLE+V_FP ≤ VCOUNT < V_VISIBLE+V_FP+V_SYNC). Default: low for VCOUNT 490..491.
  - RGB_OUT <= visible ? RGB_IN : 12'h000.
- FRAME_START: registered; asserted for exactly the one CLKIN cycle following the pe edge on which the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- EN low: on each CLKIN edge, div, the counters and all stage-1 outputs load their reset values. They stay there while EN is low. Operation restarts from div=0 when EN rises.

## Timing
- Reset values (ACLR high, asynchronous): div=0, HCOUNT=0, VCOUNT=0, HSYNC=1, VSYNC=1, VIDEO_ON=0, RGB_OUT=0, FRAME_START=0. PIX_REQ follows its decode, so it is 1 when EN=1.
- After ACLR falls, the first pe occurs on the CLK_DIV-th rising CLKIN edge (the 4th by default). HCOUNT becomes 1 there.
- Latency from a coordinate appearing on HCOUNT/VCOUNT to its RGB_OUT/HSYNC/VSYNC/VIDEO_ON is 1 pixel period (CLK_DIV CLKIN cycles). Sync and RGB outputs are always mutually aligned.
- Line period: H_TOTAL*CLK_DIV CLKIN cycles (3200). Frame period: H_TOTAL*V_TOTAL*CLK_DIV CLKIN cycles (1,680,000).
- Simultaneous events:
  - ACLR overrides EN.
  - The EN-low restart overrides a pending pe.
  - An HCOUNT wrap and a VCOUNT wrap on the same pe is a normal frame wrap.
- Reset mid-line or mid-frame: all outputs take reset values immediately. No partial sync pulse is extended.

## Test plan
- Reset release, EN=1, RGB_IN=12'hFFF: HCOUNT reaches 1 on the 4th CLKIN edge. RGB_OUT=FFF and VIDEO_ON=1 appear exactly 4 CLKIN cycles after HCOUNT=0,VCOUNT=0 was presented.
- Full line: HSYNC low for exactly 96 pixels (384 CLKIN cycles), starting 656 pixels after stage-1 pixel 0. Line period is 3200 cycles. RGB_OUT is 0 and VIDEO_ON is 0 for pixels 640..799 even with RGB_IN=FFF.
- Full frame: VSYNC low for exactly 2 lines (lines 490–491). FRAME_START pulses once per 1,680,000 cycles, for one cycle only, after the (799,524)→(0,0) wrap.
- PIX_REQ check: PIX_REQ is high for 640 pixels per visible line and low on lines 480..524. A source returning a pattern of HCOUNT[3:0] replicated appears on RGB_OUT with 1-pixel lag.
- Mid-frame ACLR at HCOUNT=700, VCOUNT=491 (both syncs low): HSYNC=VSYNC=1, counters=0 and RGB_OUT=0 asynchronously. Normal restart follows the release.
- EN dropped for 10 cycles mid-line, then raised: outputs hold reset values while EN is low. The first pe comes 4 cycles after EN rises, and the line restarts from (0,0).
